// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard.
//   stall_cause_e : code that reports which hazard is holding the ID stage
//   timer_width() : bit width of a countdown timer that can hold a given latency
package hazard_scoreboard_pkg;

   typedef enum logic [2:0] {
      STALL_NONE = 3'd0,
      STALL_MDU  = 3'd1,
      STALL_LOAD = 3'd2,
      STALL_ALU  = 3'd3,
      STALL_CP0  = 3'd4
   } stall_cause_e;

   // The width is never zero, so a disabled hazard class (latency 0) still
   // gets a legal one-bit timer that is only ever loaded with 0.
   function automatic int unsigned timer_width(input int unsigned max_lat);
      return (max_lat == 0) ? 1 : $clog2(max_lat + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_countdown_timer.sv
// countdown_timer: one readiness timer of the hazard scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   load       : take 'value' this cycle; this wins over the decrement
//   value      : latency loaded on 'load'
//   dec        : count down by one while the count is nonzero
//   nonzero    : count is not yet zero, i.e. the tracked result is not ready
module countdown_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic         nonzero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign nonzero = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage interlock of the 5-stage pipeline.
// Every GPR, every CP0 register and the MUL/DIV unit owns a countdown timer
// that is loaded when a producer issues and says "not ready yet" while it is
// nonzero. The instruction in ID is checked against the current timers.
//   Inputs : id_* decoded fields of the ID instruction, flush kills it.
//   Outputs: stall_if / stall_id / bubble_exe freeze the front end and insert
//            a bubble; issue moves the instruction to EXE; stall_cause names
//            the highest-priority hazard; mdu_busy; stall_cnt perf counter.
// Handshake: ID presents an instruction with id_valid. In any cycle exactly
// one of {issue, stall, neither} holds. 'Neither' means id_valid is low or
// flush is high. While stalled, ID must keep presenting the same instruction.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int ALU_LAT  = 1,
   parameter int LOAD_LAT = 2,
   parameter int MDU_LAT  = 32,
   parameter int CP0_LAT  = 1,
   parameter int PERF_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_reg_write,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_mem_read,
   input  logic              id_cp0_read,
   input  logic              id_cp0_write,
   input  logic              id_mdu_start,
   input  logic              id_use_hilo,
   input  logic              flush,
   output logic              stall_if,
   output logic              stall_id,
   output logic              bubble_exe,
   output logic              issue,
   output logic [2:0]        stall_cause,
   output logic              mdu_busy,
   output logic [PERF_W-1:0] stall_cnt
);

   localparam int NUM_CP0 = 2 ** REG_AW;
   localparam int REG_TW  = timer_width((ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT);
   localparam int MDU_TW  = timer_width(MDU_LAT);
   localparam int CP0_TW  = timer_width(CP0_LAT);

   localparam logic [REG_TW-1:0] ALU_VAL  = REG_TW'(ALU_LAT);
   localparam logic [REG_TW-1:0] LOAD_VAL = REG_TW'(LOAD_LAT);
   localparam logic [MDU_TW-1:0] MDU_VAL  = MDU_TW'(MDU_LAT);
   localparam logic [CP0_TW-1:0] CP0_VAL  = CP0_TW'(CP0_LAT);

   logic [NUM_REGS-1:0] reg_nz;
   logic [NUM_CP0-1:0]  cp0_nz;
   logic                mdu_nz;

   // Per-GPR flag: the pending result comes from a load (else from the ALU).
   logic [NUM_REGS-1:0] reg_is_load_q;
   logic [NUM_REGS-1:0] reg_is_load_d;
   logic [PERF_W-1:0]   stall_cnt_q;
   logic [PERF_W-1:0]   stall_cnt_d;

   logic         rs_busy, rt_busy;
   logic         mdu_haz, load_haz, alu_haz, cp0_haz;
   logic         live, stall;
   stall_cause_e cause;

   // Register 0 is hard-wired and never waits.
   assign reg_nz[0] = 1'b0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      logic ld;
      assign ld = issue && id_reg_write && (id_dst == REG_AW'(g));
      countdown_timer #(.W(REG_TW)) u_timer (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (ld),
         .value   (id_mem_read ? LOAD_VAL : ALU_VAL),
         .dec     (1'b1),
         .nonzero (reg_nz[g])
      );
   end

   for (genvar g = 0; g < NUM_CP0; g++) begin : g_cp0
      logic ld;
      assign ld = issue && id_cp0_write && (id_rd == REG_AW'(g));
      countdown_timer #(.W(CP0_TW)) u_timer (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (ld),
         .value   (CP0_VAL),
         .dec     (1'b1),
         .nonzero (cp0_nz[g])
      );
   end

   countdown_timer #(.W(MDU_TW)) u_mdu_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (issue && id_mdu_start),
      .value   (MDU_VAL),
      .dec     (1'b1),
      .nonzero (mdu_nz)
   );

   always_comb begin
      rs_busy  = id_use_rs && reg_nz[id_rs];
      rt_busy  = id_use_rt && reg_nz[id_rt];
      mdu_haz  = mdu_nz && (id_mdu_start || id_use_hilo);
      load_haz = (rs_busy && reg_is_load_q[id_rs]) || (rt_busy && reg_is_load_q[id_rt]);
      alu_haz  = (rs_busy && !reg_is_load_q[id_rs]) || (rt_busy && !reg_is_load_q[id_rt]);
      cp0_haz  = id_cp0_read && cp0_nz[id_rd];

      cause = STALL_NONE;
      if (mdu_haz) begin
         cause = STALL_MDU;
      end else if (load_haz) begin
         cause = STALL_LOAD;
      end else if (alu_haz) begin
         cause = STALL_ALU;
      end else if (cp0_haz) begin
         cause = STALL_CP0;
      end

      // A flushed instruction neither issues nor stalls.
      live  = id_valid && !flush;
      stall = live && (cause != STALL_NONE);
      issue = live && !stall;
   end

   always_comb begin
      reg_is_load_d = reg_is_load_q;
      if (issue && id_reg_write && (id_dst != '0)) begin
         reg_is_load_d[id_dst] = id_mem_read;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_is_load_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         reg_is_load_q <= reg_is_load_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign stall_if    = stall;
   assign stall_id    = stall;
   assign bubble_exe  = stall;
   assign stall_cause = stall ? cause : STALL_NONE;
   assign mdu_busy    = mdu_nz;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random
// instruction streams, checked cycle by cycle against a reference model that
// tracks, per resource, the absolute cycle from which its result is ready.
module tb_hazard_scoreboard;

   localparam int ALU_LAT  = 1;
   localparam int LOAD_LAT = 2;
   localparam int MDU_LAT  = 32;
   localparam int CP0_LAT  = 1;
   localparam int SAT_MAX  = 65535;

   typedef struct packed {
      logic [4:0] rs, rt, rd, dst;
      logic use_rs, use_rt, reg_write, mem_read;
      logic cp0_read, cp0_write, mdu_start, use_hilo;
   } instr_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0, id_dst = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
   logic       id_cp0_read = 1'b0, id_cp0_write = 1'b0, id_mdu_start = 1'b0, id_use_hilo = 1'b0;
   logic       flush = 1'b0;

   logic        stall_if, stall_id, bubble_exe, issue, mdu_busy;
   logic [2:0]  stall_cause;
   logic [15:0] stall_cnt;

   logic        f_stall_if, f_stall_id, f_bubble_exe, f_issue, f_mdu_busy;
   logic [2:0]  f_stall_cause;
   logic [15:0] f_stall_cnt;

   hazard_scoreboard u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_reg_write(id_reg_write), .id_dst(id_dst), .id_mem_read(id_mem_read),
      .id_cp0_read(id_cp0_read), .id_cp0_write(id_cp0_write),
      .id_mdu_start(id_mdu_start), .id_use_hilo(id_use_hilo), .flush(flush),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_exe(bubble_exe),
      .issue(issue), .stall_cause(stall_cause), .mdu_busy(mdu_busy),
      .stall_cnt(stall_cnt)
   );

   // Full-forwarding variant, only inspected in the ALU scenario.
   hazard_scoreboard #(.ALU_LAT(0)) u_fwd (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_reg_write(id_reg_write), .id_dst(id_dst), .id_mem_read(id_mem_read),
      .id_cp0_read(id_cp0_read), .id_cp0_write(id_cp0_write),
      .id_mdu_start(id_mdu_start), .id_use_hilo(id_use_hilo), .flush(flush),
      .stall_if(f_stall_if), .stall_id(f_stall_id), .bubble_exe(f_bubble_exe),
      .issue(f_issue), .stall_cause(f_stall_cause), .mdu_busy(f_mdu_busy),
      .stall_cnt(f_stall_cnt)
   );

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   int cyc = 0;
   int reg_ready[32];
   bit reg_ld[32];
   int cp0_ready[32];
   int mdu_ready = 0;
   int exp_cnt = 0;

   bit obs_issue, obs_stall, obs_busy;
   logic [2:0] obs_cause;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         reg_ready[i] = 0;
         reg_ld[i]    = 1'b0;
         cp0_ready[i] = 0;
      end
      mdu_ready = 0;
      exp_cnt   = 0;
   endtask

   function automatic bit src_haz(input bit use_r, input logic [4:0] r, input bit want_load);
      return use_r && (r != 0) && (cyc < reg_ready[r]) && (reg_ld[r] == want_load);
   endfunction

   // One pipeline cycle: compare at the falling edge, then advance the model
   // by what the specified behaviour says happens at the next rising edge.
   task automatic cycle_check();
      bit m_mdu, m_load, m_alu, m_cp0, live, m_stall, m_issue;
      logic [2:0] m_cause;
      @(negedge clk);
      m_mdu  = (cyc < mdu_ready) && (id_mdu_start || id_use_hilo);
      m_load = src_haz(id_use_rs, id_rs, 1'b1) || src_haz(id_use_rt, id_rt, 1'b1);
      m_alu  = src_haz(id_use_rs, id_rs, 1'b0) || src_haz(id_use_rt, id_rt, 1'b0);
      m_cp0  = id_cp0_read && (cyc < cp0_ready[id_rd]);
      live    = id_valid && !flush;
      m_stall = live && (m_mdu || m_load || m_alu || m_cp0);
      m_issue = live && !m_stall;
      m_cause = !m_stall ? 3'd0 : m_mdu ? 3'd1 : m_load ? 3'd2 : m_alu ? 3'd3 : 3'd4;
      exp_q.push_back({m_stall, m_stall, m_stall, m_issue, m_cause, 1'(cyc < mdu_ready)});
      check_eq("outs", 32'({stall_if, stall_id, bubble_exe, issue, stall_cause, mdu_busy}),
               32'(exp_q.pop_front()));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
      obs_issue = issue;
      obs_stall = stall_id;
      obs_cause = stall_cause;
      obs_busy  = mdu_busy;
      if (m_stall && exp_cnt != SAT_MAX) exp_cnt++;
      if (m_issue) begin
         if (id_reg_write && id_dst != 0) begin
            reg_ready[id_dst] = cyc + 1 + (id_mem_read ? LOAD_LAT : ALU_LAT);
            reg_ld[id_dst]    = id_mem_read;
         end
         if (id_mdu_start) mdu_ready = cyc + 1 + MDU_LAT;
         if (id_cp0_write) cp0_ready[id_rd] = cyc + 1 + CP0_LAT;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver ----------------
   task automatic apply(input instr_t ins, input bit valid, input bit fl);
      id_valid = valid;   flush = fl;
      id_rs = ins.rs;     id_rt = ins.rt;   id_rd = ins.rd;   id_dst = ins.dst;
      id_use_rs = ins.use_rs;       id_use_rt = ins.use_rt;
      id_reg_write = ins.reg_write; id_mem_read = ins.mem_read;
      id_cp0_read = ins.cp0_read;   id_cp0_write = ins.cp0_write;
      id_mdu_start = ins.mdu_start; id_use_hilo = ins.use_hilo;
   endtask

   function automatic instr_t mk_alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
      instr_t i = '0;
      i.dst = dst; i.rs = rs; i.rt = rt; i.use_rs = 1'b1; i.use_rt = 1'b1; i.reg_write = 1'b1;
      return i;
   endfunction

   function automatic instr_t mk_load(input logic [4:0] dst, input logic [4:0] base);
      instr_t i = '0;
      i.dst = dst; i.rs = base; i.use_rs = 1'b1; i.reg_write = 1'b1; i.mem_read = 1'b1;
      return i;
   endfunction

   function automatic instr_t mk_div(input logic [4:0] rs, input logic [4:0] rt);
      instr_t i = '0;
      i.rs = rs; i.rt = rt; i.use_rs = 1'b1; i.use_rt = 1'b1; i.mdu_start = 1'b1;
      return i;
   endfunction

   function automatic instr_t mk_mflo(input logic [4:0] dst);
      instr_t i = '0;
      i.dst = dst; i.reg_write = 1'b1; i.use_hilo = 1'b1;
      return i;
   endfunction

   function automatic instr_t mk_cp0(input bit wr, input logic [4:0] rd, input logic [4:0] gpr);
      instr_t i = '0;
      i.rd = rd; i.rt = gpr;
      if (wr) begin
         i.use_rt = 1'b1; i.cp0_write = 1'b1;
      end else begin
         i.dst = gpr; i.reg_write = 1'b1; i.cp0_read = 1'b1;
      end
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i.rs = 5'($urandom_range(0, 7));  i.rt = 5'($urandom_range(0, 7));
      i.dst = 5'($urandom_range(0, 7)); i.rd = 5'($urandom_range(10, 13));
      i.use_rs = 1'($urandom_range(0, 1));      i.use_rt = 1'($urandom_range(0, 1));
      i.reg_write = ($urandom_range(0, 99) < 60);
      i.mem_read  = ($urandom_range(0, 99) < 30);
      i.cp0_read  = ($urandom_range(0, 99) < 10);
      i.cp0_write = ($urandom_range(0, 99) < 10);
      i.mdu_start = ($urandom_range(0, 99) < 3);
      i.use_hilo  = ($urandom_range(0, 99) < 5);
      return i;
   endfunction

   task automatic drain(input int n);
      apply('0, 1'b0, 1'b0);
      repeat (n) cycle_check();
   endtask

   // Hold one instruction in ID until it issues; count the stall cycles.
   task automatic run_instr(input instr_t ins, input string tag, input int exp_stalls,
                            input logic [2:0] exp_cause);
      int stalls = 0;
      bit done = 1'b0;
      logic [2:0] first_cause = 3'd0;
      apply(ins, 1'b1, 1'b0);
      for (int k = 0; k < 200 && !done; k++) begin
         cycle_check();
         if (obs_issue) begin
            done = 1'b1;
         end else if (obs_stall) begin
            if (stalls == 0) first_cause = obs_cause;
            stalls++;
         end
      end
      check_eq({tag, "_issued"}, 32'(done), 32'd1);
      check_eq({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      if (exp_stalls > 0) check_eq({tag, "_cause"}, 32'(first_cause), 32'(exp_cause));
      apply('0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear at once.
   task automatic async_reset();
      @(negedge clk);
      #2;
      apply('0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("rst_outs", 32'({stall_if, stall_id, bubble_exe, issue, stall_cause, mdu_busy}), 32'd0);
      check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int busy_cycles;
      int sat_stalls;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check_eq("init_cnt", 32'(stall_cnt), 32'd0);
      check_eq("init_busy", 32'(mdu_busy), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      drain(2);

      // ALU producer -> consumer; the ALU_LAT=0 copy must not stall.
      run_instr(mk_alu(5'd3, 5'd1, 5'd2), "addu3", 0, 3'd0);
      apply(mk_alu(5'd4, 5'd3, 5'd1), 1'b1, 1'b0);
      #1;
      check_eq("fwd_issue", 32'(f_issue), 32'd1);
      check_eq("fwd_stall", 32'(f_stall_id), 32'd0);
      run_instr(mk_alu(5'd4, 5'd3, 5'd1), "sub4", 1, 3'd3);
      drain(4);

      // Load-use
      run_instr(mk_load(5'd5, 5'd1), "lw5", 0, 3'd0);
      run_instr(mk_alu(5'd6, 5'd5, 5'd0), "use5", 2, 3'd2);
      drain(4);

      // Writes to $0 never create a hazard
      run_instr(mk_load(5'd0, 5'd1), "lw0", 0, 3'd0);
      run_instr(mk_alu(5'd7, 5'd0, 5'd0), "use0", 0, 3'd0);
      drain(4);

      // MUL/DIV busy window, second div and mflo
      run_instr(mk_div(5'd1, 5'd2), "div_a", 0, 3'd0);
      busy_cycles = 0;
      for (int k = 0; k < 40; k++) begin
         cycle_check();
         if (obs_busy) busy_cycles++;
      end
      check_eq("mdu_busy_len", 32'(busy_cycles), 32'd32);
      run_instr(mk_div(5'd1, 5'd2), "div_b", 0, 3'd0);
      run_instr(mk_div(5'd3, 5'd4), "div_c", 32, 3'd1);
      run_instr(mk_mflo(5'd8), "mflo", 32, 3'd1);
      drain(4);

      // CP0 move
      run_instr(mk_cp0(1'b1, 5'd12, 5'd2), "mtc0_12", 0, 3'd0);
      run_instr(mk_cp0(1'b0, 5'd12, 5'd9), "mfc0_12", 1, 3'd4);
      drain(4);
      run_instr(mk_cp0(1'b1, 5'd12, 5'd2), "mtc0_12b", 0, 3'd0);
      run_instr(mk_cp0(1'b0, 5'd13, 5'd9), "mfc0_13", 0, 3'd0);
      drain(4);

      // Flush while a load hazard is pending: the timer keeps running
      run_instr(mk_load(5'd5, 5'd1), "lw5f", 0, 3'd0);
      apply(mk_alu(5'd6, 5'd5, 5'd0), 1'b1, 1'b1);
      cycle_check();
      check_eq("flush_issue", 32'(obs_issue), 32'd0);
      check_eq("flush_stall", 32'(obs_stall), 32'd0);
      run_instr(mk_alu(5'd6, 5'd5, 5'd0), "after_flush", 1, 3'd2);
      drain(4);

      // Random streams with a reset in the middle
      for (int k = 0; k < 1500; k++) begin
         apply(rand_instr(), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 10));
         cycle_check();
         if (k == 700) async_reset();
      end
      async_reset();

      // Saturation: keep a div in ID so it stalls on the previous one
      apply(mk_div(5'd1, 5'd2), 1'b1, 1'b0);
      sat_stalls = 0;
      for (int k = 0; k < 80000 && sat_stalls < 70000; k++) begin
         cycle_check();
         if (obs_stall) sat_stalls++;
      end
      check_eq("sat_reached", 32'(sat_stalls >= 70000), 32'd1);
      check_eq("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
      repeat (40) cycle_check();
      check_eq("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
      drain(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
